// File: rtl/div_8x4_seq.sv
// div_8x4_seq: sequential restoring divider, DW-bit dividend / VW-bit divisor.
// Produces one quotient bit per clock, MSB first, behind a start/ready/done
// handshake. A zero divisor short-circuits to DONE with an all-ones quotient.
module div_8x4_seq #(
   parameter int unsigned DW = 8,
   parameter int unsigned VW = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic [DW-1:0] dividend,
   input  logic [VW-1:0] divisor,
   output logic          ready,
   output logic          busy,
   output logic          done,
   output logic [DW-1:0] quotient,
   output logic [VW-1:0] remainder,
   output logic          div_by_zero
);

   localparam int unsigned CW = $clog2(DW);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t        state_q;

   // Datapath registers
   logic [DW-1:0] d_q;      // dividend shift register, MSB consumed first
   logic [VW-1:0] v_q;      // latched divisor
   logic [VW-1:0] r_q;      // partial remainder
   logic [DW-1:0] qs_q;     // quotient bits being assembled
   logic [CW-1:0] cnt_q;    // steps remaining after the current one

   // Registered outputs
   logic          ready_q;
   logic          busy_q;
   logic          done_q;
   logic [DW-1:0] quot_q;
   logic [VW-1:0] rem_q;
   logic          dbz_q;

   // Next-step values produced by the trial subtraction
   logic [VW:0]   trial_d;
   logic          ge_d;
   logic [VW-1:0] diff_d;
   logic [VW-1:0] r_d;
   logic [DW-1:0] qs_d;

   // One restoring step: shift in the next dividend bit and try to subtract V.
   // The remainder is kept VW bits wide: it never exceeds V-1 after a step, so
   // the top bit of the (VW+1)-bit partial remainder is always zero; the trial
   // value still carries the extra bit for the unsigned compare, and the
   // VW-bit difference is exact whenever the compare succeeds.
   always_comb begin
      trial_d = {r_q, d_q[DW-1]};
      ge_d    = (trial_d >= {1'b0, v_q});
      diff_d  = trial_d[VW-1:0] - v_q;
      r_d     = ge_d ? diff_d : trial_d[VW-1:0];
      qs_d    = {qs_q[DW-2:0], ge_d};
   end

   // Control FSM together with datapath and registered handshake/result outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         d_q     <= '0;
         v_q     <= '0;
         r_q     <= '0;
         qs_q    <= '0;
         cnt_q   <= '0;
         ready_q <= 1'b1;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         quot_q  <= '0;
         rem_q   <= '0;
         dbz_q   <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  d_q     <= dividend;
                  v_q     <= divisor;
                  r_q     <= '0;
                  qs_q    <= '0;
                  cnt_q   <= CW'(DW - 1);
                  ready_q <= 1'b0;
                  if (divisor != '0) begin
                     state_q <= S_CALC;
                     busy_q  <= 1'b1;
                  end else begin
                     state_q <= S_DONE;
                     done_q  <= 1'b1;
                     quot_q  <= '1;
                     rem_q   <= '0;
                     dbz_q   <= 1'b1;
                  end
               end
            end

            S_CALC: begin
               r_q  <= r_d;
               qs_q <= qs_d;
               d_q  <= {d_q[DW-2:0], 1'b0};
               if (cnt_q == '0) begin
                  quot_q  <= qs_d;
                  rem_q   <= r_d;
                  dbz_q   <= 1'b0;
                  state_q <= S_DONE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
               end else begin
                  cnt_q <= cnt_q - CW'(1);
               end
            end

            S_DONE: begin
               state_q <= S_IDLE;
               done_q  <= 1'b0;
               ready_q <= 1'b1;
            end

            default: begin
               state_q <= S_IDLE;
               ready_q <= 1'b1;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
            end
         endcase
      end
   end

   assign ready       = ready_q;
   assign busy        = busy_q;
   assign done        = done_q;
   assign quotient    = quot_q;
   assign remainder   = rem_q;
   assign div_by_zero = dbz_q;

endmodule
